// File: rtl/acc_collect.sv
// Purpose: ping-pong accumulator collecting partial-sum rows, then draining each full tile to the PPU.
// Latency: last beat accepted at edge t -> o_ppu_start in cycle after edge t+1, then ROWS drain cycles.
// Backpressure: o_psum_ready low only while the write bank is still full (both banks awaiting drain).
module acc_collect #(
    parameter int LANES  = 16,
    parameter int ROWS   = 16,
    parameter int PSUM_W = 16,
    parameter int ACC_W  = 24
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_psum_valid,
    output logic                    o_psum_ready,
    input  logic [3:0]              i_psum_row,
    input  logic                    i_psum_first,
    input  logic                    i_psum_last,
    input  logic [PSUM_W*LANES-1:0] i_psum_data,
    output logic                    o_ppu_start,
    output logic [ACC_W*LANES-1:0]  o_acc_data,
    output logic                    o_acc_valid,
    output logic [1:0]              o_bank_full
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int               CNT_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROWS - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    // Row storage: two banks, deliberately left out of reset.
    logic [ACC_W*LANES-1:0] bank_q [2][ROWS];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [1:0]       full_q, full_d;

    logic                   accept;
    logic                   drain_done;
    logic [ACC_W*LANES-1:0] bank_row_d;
    logic [ACC_W-1:0]       old_acc;
    logic [ACC_W-1:0]       ps_ext;
    logic [ACC_W:0]         sum;

    assign accept = i_psum_valid && !full_q[wr_bank_q];

    // New row value: overwrite on first, otherwise saturating add per lane.
    always_comb begin
        bank_row_d = '0;
        old_acc    = '0;
        ps_ext     = '0;
        sum        = '0;
        for (int k = 0; k < LANES; k++) begin
            old_acc = bank_q[wr_bank_q][i_psum_row][k*ACC_W +: ACC_W];
            ps_ext  = {{(ACC_W-PSUM_W){i_psum_data[k*PSUM_W + PSUM_W - 1]}},
                       i_psum_data[k*PSUM_W +: PSUM_W]};
            // One guard bit: overflow shows up as the top two bits disagreeing.
            sum     = {old_acc[ACC_W-1], old_acc} + {ps_ext[ACC_W-1], ps_ext};
            if (i_psum_first) begin
                bank_row_d[k*ACC_W +: ACC_W] = ps_ext;
            end else if (sum[ACC_W] != sum[ACC_W-1]) begin
                bank_row_d[k*ACC_W +: ACC_W] = sum[ACC_W] ? ACC_MIN : ACC_MAX;
            end else begin
                bank_row_d[k*ACC_W +: ACC_W] = sum[ACC_W-1:0];
            end
        end
    end

    // Bank write on every accepted beat.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            bank_q[wr_bank_q][i_psum_row] <= bank_row_d;
        end
    end

    // Drain FSM next-state: IDLE -> START (one cycle) -> DRAIN (ROWS cycles) -> IDLE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_bank_d  = rd_bank_q;
        drain_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_LAST) begin
                    drain_done = 1'b1;
                    cnt_d      = '0;
                    rd_bank_d  = ~rd_bank_q;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Full flags and write pointer: set/clear always hit different banks, so both apply.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        if (drain_done) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (accept && i_psum_last) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
        end
    end

    // Moore outputs; drain data comes only from stored rows, never from the input.
    always_comb begin
        o_psum_ready = !full_q[wr_bank_q];
        o_bank_full  = full_q;
        o_ppu_start  = (state_q == ST_START);
        o_acc_valid  = (state_q == ST_DRAIN);
        o_acc_data   = '0;
        if (state_q == ST_DRAIN) begin
            o_acc_data = bank_q[rd_bank_q][cnt_q];
        end
    end

endmodule
